// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the icache/dcache memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned MaskW      = 4;
  localparam int unsigned StarveCntW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } state_e;

  typedef enum logic {
    OwnI,
    OwnD
  } owner_e;

  // Any byte enable makes a dcache request a write, regardless of re.
  function automatic logic dcache_is_write(input logic [MaskW-1:0] we);
    return |we;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Client (icache/dcache) and backing-memory signals seen by the arbiter.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AddrW = 32,
  parameter int unsigned DataW = 32
);

  logic             icache_re;
  logic [AddrW-1:0] icache_addr;
  logic             icache_req_ready;
  logic             icache_resp_valid;
  logic [DataW-1:0] icache_dout;

  logic             dcache_re;
  logic [MaskW-1:0] dcache_we;
  logic [AddrW-1:0] dcache_addr;
  logic [DataW-1:0] dcache_din;
  logic             dcache_req_ready;
  logic             dcache_resp_valid;
  logic [DataW-1:0] dcache_dout;

  logic             mem_req_valid;
  logic             mem_req_ready;
  logic             mem_req_wr;
  logic [AddrW-1:0] mem_addr;
  logic [DataW-1:0] mem_wdata;
  logic [MaskW-1:0] mem_wmask;
  logic             mem_resp_valid;
  logic [DataW-1:0] mem_rdata;

  modport slave (
    input  icache_re, icache_addr,
    output icache_req_ready, icache_resp_valid, icache_dout,
    input  dcache_re, dcache_we, dcache_addr, dcache_din,
    output dcache_req_ready, dcache_resp_valid, dcache_dout,
    output mem_req_valid, mem_req_wr, mem_addr, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport master (
    output icache_re, icache_addr,
    input  icache_req_ready, icache_resp_valid, icache_dout,
    output dcache_re, dcache_we, dcache_addr, dcache_din,
    input  dcache_req_ready, dcache_resp_valid, dcache_dout,
    input  mem_req_valid, mem_req_wr, mem_addr, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );

endinterface

// File: rtl/mem_arbiter_slot.sv
// One-entry request holding register for a single arbiter client.
module mem_arbiter_slot
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AddrW = 32,
  parameter int unsigned DataW = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  input  logic             wr_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [DataW-1:0] data_i,
  input  logic [MaskW-1:0] mask_i,
  input  logic             free_i,
  output logic             ready_o,
  output logic             pend_o,
  output logic             wr_o,
  output logic [AddrW-1:0] addr_o,
  output logic [DataW-1:0] data_o,
  output logic [MaskW-1:0] mask_o
);

  logic             valid_q;
  logic             wr_q;
  logic [AddrW-1:0] addr_q;
  logic [DataW-1:0] data_q;
  logic [MaskW-1:0] mask_q;
  logic             capture;

  assign ready_o = ~valid_q;
  assign capture = req_i & ~valid_q;

  // The pending view includes a request being captured this edge, so the
  // arbiter can grant it without waiting a cycle for the slot to fill.
  always_comb begin
    pend_o = valid_q | capture;
    wr_o   = capture ? wr_i   : wr_q;
    addr_o = capture ? addr_i : addr_q;
    data_o = capture ? data_i : data_q;
    mask_o = capture ? mask_i : mask_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
    end else if (free_i) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q <= 1'b1;
      wr_q    <= wr_i;
      addr_q  <= addr_i;
      data_q  <= data_i;
      mask_q  <= mask_i;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between icache and dcache: dcache priority with an
// icache starvation guard, one transaction in flight, read data routed back.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AddrW       = 32,
  parameter int unsigned DataW       = 32,
  parameter int unsigned StarveLimit = 4
) (
  input logic          clk,
  input logic          reset_n,
  mem_arbiter_if.slave bus
);

  state_e                state_q;
  owner_e                owner_q;
  logic [StarveCntW-1:0] starve_q;
  logic                  req_valid_q;
  logic                  req_wr_q;
  logic [AddrW-1:0]      addr_q;
  logic [DataW-1:0]      wdata_q;
  logic [MaskW-1:0]      wmask_q;
  logic [DataW-1:0]      i_dout_q;
  logic [DataW-1:0]      d_dout_q;

  logic             i_ready, i_pend, i_wr, i_free;
  logic [AddrW-1:0] i_addr;
  logic [DataW-1:0] i_data;
  logic [MaskW-1:0] i_mask;
  logic             d_ready, d_pend, d_wr, d_free, d_req, d_is_wr;
  logic [AddrW-1:0] d_addr;
  logic [DataW-1:0] d_data;
  logic [MaskW-1:0] d_mask;

  logic             starve_hit;
  owner_e           grant_own;
  logic             g_wr;
  logic [AddrW-1:0] g_addr;
  logic [DataW-1:0] g_data;
  logic [MaskW-1:0] g_mask;
  logic             done;
  logic             resp_fire;
  logic             i_resp;
  logic             d_resp;

  assign d_is_wr = dcache_is_write(bus.dcache_we);
  assign d_req   = d_is_wr | bus.dcache_re;

  mem_arbiter_slot #(
    .AddrW (AddrW),
    .DataW (DataW)
  ) u_islot (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .req_i   (bus.icache_re),
    .wr_i    (1'b0),
    .addr_i  (bus.icache_addr),
    .data_i  ('0),
    .mask_i  ('0),
    .free_i  (i_free),
    .ready_o (i_ready),
    .pend_o  (i_pend),
    .wr_o    (i_wr),
    .addr_o  (i_addr),
    .data_o  (i_data),
    .mask_o  (i_mask)
  );

  mem_arbiter_slot #(
    .AddrW (AddrW),
    .DataW (DataW)
  ) u_dslot (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .req_i   (d_req),
    .wr_i    (d_is_wr),
    .addr_i  (bus.dcache_addr),
    .data_i  (bus.dcache_din),
    .mask_i  (bus.dcache_we),
    .free_i  (d_free),
    .ready_o (d_ready),
    .pend_o  (d_pend),
    .wr_o    (d_wr),
    .addr_o  (d_addr),
    .data_o  (d_data),
    .mask_o  (d_mask)
  );

  always_comb begin
    starve_hit = i_pend && (starve_q == StarveCntW'(StarveLimit));
    grant_own  = (d_pend && !starve_hit) ? OwnD : OwnI;
    g_wr       = (grant_own == OwnD) ? d_wr   : i_wr;
    g_addr     = (grant_own == OwnD) ? d_addr : i_addr;
    g_data     = (grant_own == OwnD) ? d_data : i_data;
    g_mask     = (grant_own == OwnD) ? d_mask : i_mask;

    resp_fire  = (state_q == StWait) && bus.mem_resp_valid;
    done       = ((state_q == StIssue) && bus.mem_req_ready && req_wr_q) || resp_fire;
    i_free     = done && (owner_q == OwnI);
    d_free     = done && (owner_q == OwnD);
    i_resp     = resp_fire && (owner_q == OwnI);
    d_resp     = resp_fire && (owner_q == OwnD);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      owner_q     <= OwnI;
      starve_q    <= '0;
      req_valid_q <= 1'b0;
      req_wr_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (i_pend || d_pend) begin
            state_q     <= StIssue;
            owner_q     <= grant_own;
            req_valid_q <= 1'b1;
            req_wr_q    <= g_wr;
            addr_q      <= g_addr;
            wdata_q     <= g_data;
            wmask_q     <= g_mask;
            if (grant_own == OwnI) begin
              starve_q <= '0;
            end else if (i_pend && (starve_q != '1)) begin
              starve_q <= starve_q + StarveCntW'(1);
            end
          end
        end
        StIssue: begin
          if (bus.mem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= req_wr_q ? StIdle : StWait;
          end
        end
        StWait: begin
          if (bus.mem_resp_valid) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_dout_q <= '0;
      d_dout_q <= '0;
    end else begin
      if (i_resp) i_dout_q <= bus.mem_rdata;
      if (d_resp) d_dout_q <= bus.mem_rdata;
    end
  end

  assign bus.icache_req_ready  = i_ready;
  assign bus.dcache_req_ready  = d_ready;
  assign bus.icache_resp_valid = i_resp;
  assign bus.dcache_resp_valid = d_resp;
  assign bus.icache_dout       = i_resp ? bus.mem_rdata : i_dout_q;
  assign bus.dcache_dout       = d_resp ? bus.mem_rdata : d_dout_q;
  assign bus.mem_req_valid     = req_valid_q;
  assign bus.mem_req_wr        = req_wr_q;
  assign bus.mem_addr          = addr_q;
  assign bus.mem_wdata         = wdata_q;
  assign bus.mem_wmask         = wmask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;
  int   n_d;
  logic found;

  mem_arbiter_if #(
    .AddrW (32),
    .DataW (32)
  ) bus ();

  mem_arbiter #(
    .AddrW       (32),
    .DataW       (32),
    .StarveLimit (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled mid-cycle.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    bus.icache_re      = 1'b0;
    bus.icache_addr    = '0;
    bus.dcache_re      = 1'b0;
    bus.dcache_we      = '0;
    bus.dcache_addr    = '0;
    bus.dcache_din     = '0;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
    #3;
    check("rst_i_ready", 32'(bus.icache_req_ready), 32'd1);
    check("rst_d_ready", 32'(bus.dcache_req_ready), 32'd1);
    check("rst_mem_valid", 32'(bus.mem_req_valid), 32'd0);
    check("rst_i_resp", 32'(bus.icache_resp_valid), 32'd0);
    check("rst_d_resp", 32'(bus.dcache_resp_valid), 32'd0);
    next();
    reset_n = 1'b1;

    // Single icache read
    next();
    bus.icache_re   = 1'b1;
    bus.icache_addr = 32'h100;
    settle();
    check("t1_mem_valid_pre", 32'(bus.mem_req_valid), 32'd0);
    next();
    bus.icache_re = 1'b0;
    settle();
    check("t1_mem_valid", 32'(bus.mem_req_valid), 32'd1);
    check("t1_addr", bus.mem_addr, 32'h100);
    check("t1_wr", 32'(bus.mem_req_wr), 32'd0);
    check("t1_wmask", 32'(bus.mem_wmask), 32'd0);
    check("t1_i_ready", 32'(bus.icache_req_ready), 32'd0);
    next();
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'hDEADBEEF;
    settle();
    check("t1_i_resp", 32'(bus.icache_resp_valid), 32'd1);
    check("t1_i_dout", bus.icache_dout, 32'hDEADBEEF);
    check("t1_d_resp", 32'(bus.dcache_resp_valid), 32'd0);
    next();
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
    settle();
    check("t1_i_resp_low", 32'(bus.icache_resp_valid), 32'd0);
    check("t1_i_dout_hold", bus.icache_dout, 32'hDEADBEEF);
    check("t1_i_ready_back", 32'(bus.icache_req_ready), 32'd1);

    // Simultaneous icache read and dcache write: write goes first
    next();
    bus.icache_re   = 1'b1;
    bus.icache_addr = 32'h40;
    bus.dcache_we   = 4'b0011;
    bus.dcache_addr = 32'h80;
    bus.dcache_din  = 32'h11223344;
    settle();
    next();
    bus.icache_re = 1'b0;
    bus.dcache_we = '0;
    settle();
    check("t2_w_valid", 32'(bus.mem_req_valid), 32'd1);
    check("t2_w_wr", 32'(bus.mem_req_wr), 32'd1);
    check("t2_w_addr", bus.mem_addr, 32'h80);
    check("t2_w_mask", 32'(bus.mem_wmask), 32'h3);
    check("t2_w_data", bus.mem_wdata, 32'h11223344);
    check("t2_i_ready", 32'(bus.icache_req_ready), 32'd0);
    check("t2_d_ready", 32'(bus.dcache_req_ready), 32'd0);
    next();
    settle();
    check("t2_idle_valid", 32'(bus.mem_req_valid), 32'd0);
    check("t2_no_d_resp", 32'(bus.dcache_resp_valid), 32'd0);
    check("t2_d_ready_back", 32'(bus.dcache_req_ready), 32'd1);
    next();
    settle();
    check("t2_r_valid", 32'(bus.mem_req_valid), 32'd1);
    check("t2_r_addr", bus.mem_addr, 32'h40);
    check("t2_r_wr", 32'(bus.mem_req_wr), 32'd0);
    next();
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'hCAFEF00D;
    settle();
    check("t2_i_resp", 32'(bus.icache_resp_valid), 32'd1);
    check("t2_i_dout", bus.icache_dout, 32'hCAFEF00D);
    check("t2_d_resp", 32'(bus.dcache_resp_valid), 32'd0);
    next();
    bus.mem_resp_valid = 1'b0;

    // Memory stalls for 5 cycles with both slots full
    bus.mem_req_ready = 1'b0;
    bus.dcache_re     = 1'b1;
    bus.dcache_addr   = 32'h200;
    bus.icache_re     = 1'b1;
    bus.icache_addr   = 32'h300;
    settle();
    for (int k = 0; k < 5; k++) begin
      next();
      bus.dcache_re = 1'b0;
      bus.icache_re = 1'b0;
      settle();
      check("t3_stall_valid", 32'(bus.mem_req_valid), 32'd1);
      check("t3_stall_addr", bus.mem_addr, 32'h200);
      check("t3_stall_wr", 32'(bus.mem_req_wr), 32'd0);
      check("t3_stall_i_ready", 32'(bus.icache_req_ready), 32'd0);
      check("t3_stall_d_ready", 32'(bus.dcache_req_ready), 32'd0);
    end
    next();
    bus.mem_req_ready = 1'b1;
    settle();
    check("t3_accept_valid", 32'(bus.mem_req_valid), 32'd1);
    next();
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h0D0D0D0D;
    settle();
    check("t3_d_resp", 32'(bus.dcache_resp_valid), 32'd1);
    check("t3_d_dout", bus.dcache_dout, 32'h0D0D0D0D);
    check("t3_i_resp", 32'(bus.icache_resp_valid), 32'd0);
    next();
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
    settle();
    check("t3_idle_valid", 32'(bus.mem_req_valid), 32'd0);
    check("t3_d_dout_hold", bus.dcache_dout, 32'h0D0D0D0D);
    next();
    settle();
    check("t3_i_valid", 32'(bus.mem_req_valid), 32'd1);
    check("t3_i_addr", bus.mem_addr, 32'h300);
    next();
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h33333333;
    settle();
    check("t3_i_resp2", 32'(bus.icache_resp_valid), 32'd1);
    check("t3_i_dout", bus.icache_dout, 32'h33333333);
    next();
    bus.mem_resp_valid = 1'b0;
    settle();

    // dcache writes every chance it gets while icache waits
    n_d   = 0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      next();
      if (c == 0) begin
        bus.icache_re   = 1'b1;
        bus.icache_addr = 32'h500;
        bus.dcache_we   = 4'hF;
        bus.dcache_addr = 32'h600;
        bus.dcache_din  = 32'h66666666;
      end else begin
        bus.icache_re = 1'b0;
      end
      settle();
      if (bus.mem_req_valid) begin
        if (bus.mem_req_wr) n_d++;
        else found = 1'b1;
      end
    end
    check("t4_i_granted", 32'(found), 32'd1);
    check("t4_d_grants", 32'(n_d), 32'd4);
    check("t4_i_addr", bus.mem_addr, 32'h500);
    next();
    bus.dcache_we      = '0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h55555555;
    settle();
    check("t4_i_resp", 32'(bus.icache_resp_valid), 32'd1);
    check("t4_i_dout", bus.icache_dout, 32'h55555555);
    next();
    bus.mem_resp_valid = 1'b0;
    for (int k = 0; k < 4; k++) next();
    settle();
    check("t4_drain_valid", 32'(bus.mem_req_valid), 32'd0);
    check("t4_drain_d_ready", 32'(bus.dcache_req_ready), 32'd1);

    // Reset while a dcache read waits for data
    next();
    bus.dcache_re   = 1'b1;
    bus.dcache_addr = 32'h700;
    settle();
    next();
    bus.dcache_re = 1'b0;
    settle();
    check("t5_issue_valid", 32'(bus.mem_req_valid), 32'd1);
    check("t5_issue_addr", bus.mem_addr, 32'h700);
    next();
    settle();
    check("t5_wait_valid", 32'(bus.mem_req_valid), 32'd0);
    check("t5_wait_d_ready", 32'(bus.dcache_req_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    check("t5_rst_d_ready", 32'(bus.dcache_req_ready), 32'd1);
    check("t5_rst_i_ready", 32'(bus.icache_req_ready), 32'd1);
    check("t5_rst_valid", 32'(bus.mem_req_valid), 32'd0);
    check("t5_rst_d_resp", 32'(bus.dcache_resp_valid), 32'd0);
    next();
    reset_n            = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h77777777;
    settle();
    check("t5_late_d_resp", 32'(bus.dcache_resp_valid), 32'd0);
    check("t5_late_i_resp", 32'(bus.icache_resp_valid), 32'd0);
    next();
    bus.mem_resp_valid = 1'b0;

    // re together with full byte enables is a write
    bus.dcache_re   = 1'b1;
    bus.dcache_we   = 4'hF;
    bus.dcache_addr = 32'h900;
    bus.dcache_din  = 32'hA5A5A5A5;
    settle();
    next();
    bus.dcache_re = 1'b0;
    bus.dcache_we = '0;
    settle();
    check("t6_valid", 32'(bus.mem_req_valid), 32'd1);
    check("t6_wr", 32'(bus.mem_req_wr), 32'd1);
    check("t6_mask", 32'(bus.mem_wmask), 32'hF);
    check("t6_data", bus.mem_wdata, 32'hA5A5A5A5);
    next();
    bus.mem_resp_valid = 1'b1;
    settle();
    check("t6_no_d_resp", 32'(bus.dcache_resp_valid), 32'd0);
    check("t6_idle_valid", 32'(bus.mem_req_valid), 32'd0);
    check("t6_d_ready", 32'(bus.dcache_req_ready), 32'd1);
    next();
    bus.mem_resp_valid = 1'b0;
    settle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
